// File: rtl/rf_write_front.sv
// Register-file write front end: clears all 8 entries after reset, then queues nibble-masked writes (depth 4) and drains them on drain_en.
// Optional build macro RF_WRITE_FRONT_COALESCE_EN merges a request into the tail entry when the addresses match.
module rf_write_front (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [2:0] in_addr,
    input  logic [1:0] in_nibble_en,
    input  logic [7:0] in_data,
    input  logic       drain_en,
    output logic [1:0] write_nibble_en,
    output logic [2:0] write_addr,
    output logic [7:0] write_data,
    output logic       init_done
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [2:0]  init_cnt_r;

    logic [2:0]  q_addr_r [4];
    logic [1:0]  q_en_r   [4];
    logic [7:0]  q_data_r [4];
    logic [1:0]  head_r;
    logic [1:0]  tail_r;
    logic [2:0]  count_r;

    logic        run_s;
    logic        empty_s;
    logic        full_s;
    logic        deq_s;
    logic        rdy_s;
    logic        merge_hit_s;
    logic        accept_s;
    logic        alloc_s;
    logic        merge_s;

`ifdef RF_WRITE_FRONT_COALESCE_EN
    logic [1:0]  last_s;

    function automatic logic [7:0] merge_nibbles(
        input logic [7:0] old_data,
        input logic [7:0] new_data,
        input logic [1:0] nib_en
    );
        logic [7:0] res;
        res = old_data;
        if (nib_en[0]) begin
            res[3:0] = new_data[3:0];
        end else begin
            res[3:0] = old_data[3:0];
        end
        if (nib_en[1]) begin
            res[7:4] = new_data[7:4];
        end else begin
            res[7:4] = old_data[7:4];
        end
        return res;
    endfunction
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: the clear sweep ends after address 7
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == 3'd7) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_INIT;
        endcase
    end

    // clear-sweep address counter
    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt_r <= 3'd0;
        end else if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + 3'd1;
        end else begin
            init_cnt_r <= init_cnt_r;
        end
    end

    // queue handshake and allocate/merge decisions
    always_comb begin
        run_s   = (state_r == ST_RUN);
        empty_s = (count_r == 3'd0);
        full_s  = (count_r == 3'd4);
        deq_s   = run_s && !empty_s && drain_en;
`ifdef RF_WRITE_FRONT_COALESCE_EN
        last_s      = tail_r - 2'd1;
        // a lone entry leaving this edge cannot absorb the new request
        merge_hit_s = run_s && !empty_s && (q_addr_r[last_s] == in_addr)
                      && !(deq_s && (count_r == 3'd1));
`else
        merge_hit_s = 1'b0;
`endif
        rdy_s    = run_s && (!full_s || merge_hit_s);
        accept_s = in_val && rdy_s;
        merge_s  = accept_s && merge_hit_s;
        alloc_s  = accept_s && !merge_hit_s;
    end

    // queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= 2'd0;
            tail_r  <= 2'd0;
            count_r <= 3'd0;
        end else begin
            if (deq_s) begin
                head_r <= head_r + 2'd1;
            end else begin
                head_r <= head_r;
            end
            if (alloc_s) begin
                tail_r <= tail_r + 2'd1;
            end else begin
                tail_r <= tail_r;
            end
            case ({alloc_s, deq_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // queue entry storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                q_addr_r[i] <= 3'd0;
                q_en_r[i]   <= 2'b00;
                q_data_r[i] <= 8'h00;
            end
        end else if (alloc_s) begin
            q_addr_r[tail_r] <= in_addr;
            q_en_r[tail_r]   <= in_nibble_en;
            q_data_r[tail_r] <= in_data;
`ifdef RF_WRITE_FRONT_COALESCE_EN
        end else if (merge_s) begin
            q_en_r[last_s]   <= q_en_r[last_s] | in_nibble_en;
            q_data_r[last_s] <= merge_nibbles(q_data_r[last_s], in_data, in_nibble_en);
`endif
        end else begin
            for (int i = 0; i < 4; i++) begin
                q_addr_r[i] <= q_addr_r[i];
                q_en_r[i]   <= q_en_r[i];
                q_data_r[i] <= q_data_r[i];
            end
        end
    end

    // FSM outputs: clear sweep in INIT, queue head in RUN
    always_comb begin
        write_nibble_en = 2'b00;
        write_addr      = 3'd0;
        write_data      = 8'h00;
        init_done       = 1'b0;
        in_rdy          = 1'b0;
        case (state_r)
            ST_INIT: begin
                write_nibble_en = 2'b11;
                write_addr      = init_cnt_r;
                write_data      = 8'h00;
            end
            ST_RUN: begin
                init_done = 1'b1;
                in_rdy    = rdy_s;
                if (deq_s) begin
                    write_nibble_en = q_en_r[head_r];
                    write_addr      = q_addr_r[head_r];
                    write_data      = q_data_r[head_r];
                end else begin
                    write_nibble_en = 2'b00;
                end
            end
            default: begin
                write_nibble_en = 2'b00;
            end
        endcase
    end

    logic unused_s;
    assign unused_s = merge_s;

endmodule

// File: tb/tb_rf_write_front.sv
// Scoreboard bench for rf_write_front: a driver feeds directed and random requests into a FIFO reference,
// and a negedge monitor checks every cycle's outputs against that reference.
module tb_rf_write_front;

`ifdef RF_WRITE_FRONT_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    typedef struct {
        logic [2:0] addr;
        logic [1:0] en;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_val = 1'b0;
    logic       in_rdy;
    logic [2:0] in_addr = 3'd0;
    logic [1:0] in_nibble_en = 2'b00;
    logic [7:0] in_data = 8'h00;
    logic       drain_en = 1'b0;
    logic [1:0] write_nibble_en;
    logic [2:0] write_addr;
    logic [7:0] write_data;
    logic       init_done;

    wr_t exp_q[$];
    bit  exp_rdy = 1'b0;
    int  phase = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_issued = 0;

    rf_write_front dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
        .in_addr(in_addr), .in_nibble_en(in_nibble_en), .in_data(in_data),
        .drain_en(drain_en), .write_nibble_en(write_nibble_en),
        .write_addr(write_addr), .write_data(write_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: predicts this cycle's outputs from the reference queue and retires the issued head
    always @(negedge clk) begin
        bit issuing;
        if (reset) begin
            phase = 0;
            exp_q.delete();
            exp_rdy = 1'b0;
        end else if (phase < 8) begin
            check("init_wen", write_nibble_en, 2'b11);
            check("init_addr", write_addr, phase);
            check("init_data", write_data, 8'h00);
            check("init_done_lo", init_done, 1'b0);
            check("init_rdy_lo", in_rdy, 1'b0);
            exp_rdy = 1'b0;
            phase++;
        end else begin
            issuing = drain_en && (exp_q.size() > 0);
            exp_rdy = (exp_q.size() < 4) ||
                      (COAL && (exp_q.size() > 0) && (exp_q[$].addr == in_addr) &&
                       !(issuing && (exp_q.size() == 1)));
            check("init_done_hi", init_done, 1'b1);
            check("in_rdy", in_rdy, exp_rdy);
            if (issuing) begin
                check("wr_en", write_nibble_en, exp_q[0].en);
                check("wr_addr", write_addr, exp_q[0].addr);
                check("wr_data", write_data, exp_q[0].data);
                void'(exp_q.pop_front());
                n_issued++;
            end else begin
                check("idle_wen", write_nibble_en, 2'b00);
            end
        end
    end

    // one clock of stimulus; the reference queue absorbs any accepted request at the edge
    task automatic cycle(input bit v, input logic [2:0] a, input logic [1:0] e,
                         input logic [7:0] d, input bit dr);
        wr_t t;
        in_val = v; in_addr = a; in_nibble_en = e; in_data = d; drain_en = dr;
        @(posedge clk);
        if (v && exp_rdy && !reset) begin
            if (COAL && (exp_q.size() > 0) && (exp_q[$].addr == a)) begin
                t = exp_q[$];
                if (e[0]) t.data[3:0] = d[3:0];
                if (e[1]) t.data[7:4] = d[7:4];
                t.en = t.en | e;
                exp_q[exp_q.size()-1] = t;
            end else begin
                t.addr = a; t.en = e; t.data = d;
                exp_q.push_back(t);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        in_val = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n, input bit dr);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 2'b00, 8'h00, dr);
    endtask

    initial begin
        int sent;
        int base;
        @(posedge clk);
        #1;
        do_reset();
        idle(9, 1'b0);

        // single write, one-cycle latency
        cycle(1'b1, 3'd3, 2'b11, 8'hab, 1'b1);
        idle(3, 1'b1);

        // fill to four, fifth refused, then drain in order
        for (int i = 0; i < 5; i++) cycle(1'b1, 3'(i), 2'b11, 8'(8'h10 + i), 1'b0);
        check("fill_depth", exp_q.size(), 4);
        idle(6, 1'b1);

        // two half-writes to one address (merge only with coalescing)
        cycle(1'b1, 3'd2, 2'b01, 8'h0c, 1'b0);
        cycle(1'b1, 3'd2, 2'b10, 8'hd0, 1'b0);
        check("merge_depth", exp_q.size(), COAL ? 1 : 2);
        if (COAL) begin
            check("merge_en", exp_q[0].en, 2'b11);
            check("merge_data", exp_q[0].data, 8'hdc);
        end
        // a no-op request still takes a slot
        cycle(1'b1, 3'd6, 2'b00, 8'h55, 1'b0);
        idle(5, 1'b1);

        // reset with three queued entries
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'(4 + i), 2'b11, 8'(8'h70 + i), 1'b0);
        do_reset();
        idle(9, 1'b0);
        idle(4, 1'b1);
        check("post_reset_issued", n_issued >= 0 && exp_q.size() == 0, 1'b1);

        // random traffic
        sent = 0;
        base = n_issued;
        while (sent < 200) begin
            bit v;
            v = ($urandom_range(0, 9) < 7);
            if (v) sent++;
            cycle(v, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  8'($urandom), ($urandom_range(0, 1) == 1));
        end
        idle(8, 1'b1);
        check("rand_drained", exp_q.size(), 0);
        check("rand_some_issued", (n_issued - base) > 20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
